// File: rtl/alu_shift_arbiter_if.sv
// Handshake bundle between the two shift issue ports, the result consumer
// and the shared shift arbiter.
interface alu_shift_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_a;
   logic [SHW-1:0]   req0_shift;
   logic             req0_ready;

   logic             req1_valid;
   logic [WIDTH-1:0] req1_a;
   logic [SHW-1:0]   req1_shift;
   logic             req1_ready;

   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic             res_id;
   logic             res_ready;

   logic [15:0]      busy_cnt;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_shift,
      output req0_ready,
      input  req1_valid, req1_a, req1_shift,
      output req1_ready,
      output res_valid, res_data, res_id,
      input  res_ready,
      output busy_cnt
   );

   // Requester / consumer side
   modport master (
      output req0_valid, req0_a, req0_shift,
      input  req0_ready,
      output req1_valid, req1_a, req1_shift,
      input  req1_ready,
      input  res_valid, res_data, res_id,
      output res_ready,
      input  busy_cnt
   );
endinterface

// File: rtl/alu_shift_arbiter.sv
// Round-robin arbiter sharing one logical-left-shift unit between two
// requesters, with a single registered result slot and a stall counter.

// Logarithmic barrel shifter: stage gi shifts by 2**gi when amount bit gi is set.
module ALU_Submodule_SLL #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [SHW-1:0]   i_shamt,
   output logic [WIDTH-1:0] o_y
);
   logic [WIDTH-1:0] w_stage [0:SHW];

   assign w_stage[0] = i_a;

   genvar gi;
   generate
      for (gi = 0; gi < SHW; gi++) begin : g_stage
         assign w_stage[gi+1] = i_shamt[gi] ? (w_stage[gi] << (2**gi)) : w_stage[gi];
      end
   endgenerate

   assign o_y = w_stage[SHW];
endmodule

module alu_shift_arbiter #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input logic               clk,
   input logic               rst_n,
   alu_shift_arbiter_if.slave bus
);
   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_id;
   logic             r_rr_ptr;
   logic [15:0]      r_busy_cnt;

   logic             w_free;
   logic             w_grant_any;
   logic             w_grant_id;
   logic             w_ready0;
   logic             w_ready1;
   logic             w_accept;
   logic             w_busy_evt;
   logic [WIDTH-1:0] w_op_a;
   logic [SHW-1:0]   w_op_shift;
   logic [WIDTH-1:0] w_shift_y;

   // The result register is the only storage, so a new operation fits when
   // it is empty or being drained this cycle.
   assign w_free = !r_res_valid || bus.res_ready;

   // Round-robin pick: a lone requester always wins, a tie goes to the pointer.
   always_comb begin
      w_grant_any = bus.req0_valid || bus.req1_valid;
      w_grant_id  = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         w_grant_id = r_rr_ptr;
      end else if (bus.req1_valid) begin
         w_grant_id = 1'b1;
      end
   end

   // Readies are held low while reset is asserted even though the slot is empty.
   assign w_ready0 = rst_n && w_free && w_grant_any && !w_grant_id && bus.req0_valid;
   assign w_ready1 = rst_n && w_free && w_grant_any &&  w_grant_id && bus.req1_valid;
   assign w_accept = w_ready0 || w_ready1;

   // Operands for the shared shifter come from whichever requester is granted.
   assign w_op_a     = w_grant_id ? bus.req1_a     : bus.req0_a;
   assign w_op_shift = w_grant_id ? bus.req1_shift : bus.req0_shift;

   ALU_Submodule_SLL #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_sll (
      .i_a     (w_op_a),
      .i_shamt (w_op_shift),
      .o_y     (w_shift_y)
   );

   // Result slot and fairness pointer: accept overwrites, pure consume empties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_id    <= 1'b0;
         r_rr_ptr    <= 1'b0;
      end else if (w_accept) begin
         r_res_valid <= 1'b1;
         r_res_data  <= w_shift_y;
         r_res_id    <= w_grant_id;
         r_rr_ptr    <= ~w_grant_id;
      end else if (r_res_valid && bus.res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

   // Any requester left waiting this cycle counts as a stall cycle.
   assign w_busy_evt = (bus.req0_valid && !w_ready0) || (bus.req1_valid && !w_ready1);

   // Saturating stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy_cnt <= '0;
      end else if (w_busy_evt && (r_busy_cnt != 16'hFFFF)) begin
         r_busy_cnt <= r_busy_cnt + 16'd1;
      end
   end

   assign bus.req0_ready = w_ready0;
   assign bus.req1_ready = w_ready1;
   assign bus.res_valid  = r_res_valid;
   assign bus.res_data   = r_res_data;
   assign bus.res_id     = r_res_id;
   assign bus.busy_cnt   = r_busy_cnt;
endmodule

// File: tb/tb_alu_shift_arbiter.sv
// Directed bench for alu_shift_arbiter with a result scoreboard and a small
// reference model of arbitration, the result slot and the stall counter.
module tb_alu_shift_arbiter;
   localparam int WIDTH = 16;
   localparam int SHW   = 4;

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] data;
   } res_t;

   logic clk;
   logic rst_n;

   alu_shift_arbiter_if #(.WIDTH(WIDTH), .SHW(SHW)) bus_if ();

   alu_shift_arbiter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   res_t        sb_q[$];
   res_t        m_last;
   bit          m_valid;
   bit          m_rr;
   logic [15:0] m_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_last  = '0;
      m_valid = 1'b0;
      m_rr    = 1'b0;
      m_busy  = 16'd0;
   endtask

   task automatic drive(input bit v0, input logic [WIDTH-1:0] a0, input logic [SHW-1:0] s0,
                        input bit v1, input logic [WIDTH-1:0] a1, input logic [SHW-1:0] s1,
                        input bit rr);
      bus_if.req0_valid = v0;
      bus_if.req0_a     = a0;
      bus_if.req0_shift = s0;
      bus_if.req1_valid = v1;
      bus_if.req1_a     = a1;
      bus_if.req1_shift = s1;
      bus_if.res_ready  = rr;
   endtask

   // One clock: inputs already driven; compare at the falling edge, then
   // advance the model to what the coming rising edge should produce.
   task automatic cycle(input bit chk);
      bit free, v0, v1, g_any, g_id, e_r0, e_r1;
      logic [WIDTH-1:0] sh_v;
      res_t r;
      @(negedge clk);
      v0    = bus_if.req0_valid;
      v1    = bus_if.req1_valid;
      free  = !m_valid || bus_if.res_ready;
      g_any = v0 || v1;
      g_id  = (v0 && v1) ? m_rr : v1;
      e_r0  = free && g_any && !g_id && v0;
      e_r1  = free && g_any && g_id && v1;
      if (chk) begin
         check("req0_ready", {31'd0, bus_if.req0_ready}, {31'd0, e_r0});
         check("req1_ready", {31'd0, bus_if.req1_ready}, {31'd0, e_r1});
         check("res_valid", {31'd0, bus_if.res_valid}, {31'd0, m_valid});
         check("busy_cnt", {16'd0, bus_if.busy_cnt}, {16'd0, m_busy});
         if (m_valid && sb_q.size() > 0) r = sb_q[0];
         else r = m_last;
         check("res_data", {16'd0, bus_if.res_data}, {16'd0, r.data});
         check("res_id", {31'd0, bus_if.res_id}, {31'd0, r.id});
         $display("cycle t=%0t v0=%0b v1=%0b rdy=%0b%0b res_valid=%0b data=%0d id=%0b busy=%0d",
                  $time, v0, v1, bus_if.req1_ready, bus_if.req0_ready, bus_if.res_valid,
                  bus_if.res_data, bus_if.res_id, bus_if.busy_cnt);
      end
      if (m_valid && bus_if.res_ready) begin
         m_last  = sb_q.pop_front();
         m_valid = 1'b0;
      end
      if (e_r0 || e_r1) begin
         sh_v   = g_id ? bus_if.req1_a : bus_if.req0_a;
         sh_v   = sh_v << (g_id ? bus_if.req1_shift : bus_if.req0_shift);
         r.id   = g_id;
         r.data = sh_v;
         sb_q.push_back(r);
         m_valid = 1'b1;
         m_rr    = !g_id;
      end
      if (((v0 && !e_r0) || (v1 && !e_r1)) && m_busy != 16'hFFFF) m_busy = m_busy + 16'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with a request pending: readies must stay low.
      rst_n = 1'b0;
      model_reset();
      drive(1'b1, 16'd15, 4'd2, 1'b0, 16'd0, 4'd0, 1'b1);
      #12;
      check("rst_res_valid", {31'd0, bus_if.res_valid}, 32'd0);
      check("rst_res_data", {16'd0, bus_if.res_data}, 32'd0);
      check("rst_res_id", {31'd0, bus_if.res_id}, 32'd0);
      check("rst_busy", {16'd0, bus_if.busy_cnt}, 32'd0);
      check("rst_req0_ready", {31'd0, bus_if.req0_ready}, 32'd0);
      drive(1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single request from requester 0: 15 << 2 = 60.
      drive(1'b1, 16'd15, 4'd2, 1'b0, 16'd0, 4'd0, 1'b1);
      cycle(1'b1);
      drive(1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b1);
      cycle(1'b1);
      cycle(1'b1);
      check("plan_data60", {16'd0, m_last.data}, 32'd60);

      // Both valid continuously: alternating grants starting with 0.
      drive(1'b1, 16'd1, 4'd15, 1'b1, 16'd10, 4'd0, 1'b1);
      for (int i = 0; i < 8; i++) cycle(1'b1);
      drive(1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b1);
      cycle(1'b1);
      cycle(1'b1);

      // Backpressure: req1 3<<4 = 48 held while req0 waits five cycles.
      drive(1'b0, 16'd0, 4'd0, 1'b1, 16'd3, 4'd4, 1'b1);
      cycle(1'b1);
      drive(1'b1, 16'd5, 4'd1, 1'b0, 16'd0, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1);
      drive(1'b1, 16'd5, 4'd1, 1'b0, 16'd0, 4'd0, 1'b1);
      cycle(1'b1);
      drive(1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b1);
      cycle(1'b1);
      cycle(1'b1);

      // Pointer retention across idle cycles.
      drive(1'b1, 16'hA5A5, 4'd3, 1'b0, 16'd0, 4'd0, 1'b1);
      cycle(1'b1);
      drive(1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1);
      drive(1'b1, 16'h8001, 4'd7, 1'b1, 16'h1234, 4'd8, 1'b1);
      cycle(1'b1);
      cycle(1'b1);
      drive(1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b1);
      cycle(1'b1);
      cycle(1'b1);

      // Reset while a result (60) is stalled in the register.
      drive(1'b1, 16'd15, 4'd2, 1'b0, 16'd0, 4'd0, 1'b0);
      cycle(1'b1);
      drive(1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b0);
      cycle(1'b1);
      drive(1'b1, 16'd15, 4'd2, 1'b1, 16'd7, 4'd1, 1'b1);
      rst_n = 1'b0;
      #2;
      check("arst_res_valid", {31'd0, bus_if.res_valid}, 32'd0);
      check("arst_busy", {16'd0, bus_if.busy_cnt}, 32'd0);
      check("arst_req0_ready", {31'd0, bus_if.req0_ready}, 32'd0);
      check("arst_req1_ready", {31'd0, bus_if.req1_ready}, 32'd0);
      model_reset();
      drive(1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, 16'd15, 4'd2, 1'b1, 16'd7, 4'd1, 1'b1);
      cycle(1'b1);
      cycle(1'b1);
      drive(1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b1);
      cycle(1'b1);
      cycle(1'b1);

      // Stall counter saturation with a full, unconsumed result register.
      drive(1'b0, 16'd0, 4'd0, 1'b1, 16'd1, 4'd1, 1'b0);
      cycle(1'b1);
      for (int i = 0; i < 70000; i++) cycle(1'b0);
      check("busy_sat", {16'd0, bus_if.busy_cnt}, 32'h0000FFFF);
      cycle(1'b1);
      cycle(1'b1);
      check("busy_hold", {16'd0, bus_if.busy_cnt}, 32'h0000FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_shift_arbiter.md
Name: alu_shift_arbiter

Overview:
- Shares one ALU_Submodule_SLL instance (16-bit logical left shift, 4-bit amount) between two requesters.
- Arbitration is round-robin.
- Each requester uses a valid/ready handshake.
- The block registers one result and returns it with the ID of the requester that issued it.
- It sits between the two issue ports of the ALU sequencing logic and the shift datapath.

Parameters:
- WIDTH, 16, operand/result width; must equal the shift submodule width.
- SHW, 4, shift-amount width; the legal shift range is 0..2**SHW-1.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_a  input  WIDTH  requester 0 operand.
- req0_shift  input  SHW  requester 0 shift amount.
- req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
- req1_valid, req1_a, req1_shift, req1_ready: same as requester 0, for requester 1.
- res_valid  output  1  result register holds an unconsumed result.
- res_data  output  WIDTH  registered shift result.
- res_id  output  1  requester that issued the result (0 or 1).
- res_ready  input  1  consumer accepts the result when high with res_valid.
- busy_cnt  output  16  count of cycles in which any reqN_valid was high but not accepted; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous):
  - res_valid=0, res_data=0, res_id=0.
  - Round-robin pointer (rr_ptr) = 0, busy_cnt = 0.
  - req0_ready = req1_ready = 0 while rst_n is low.
- Slot free: free = !res_valid || res_ready. The shift result register is the only storage.
- Arbitration (combinational, each cycle):
  - Only requester 0 valid: grant 0.
  - Only requester 1 valid: grant 1.
  - Both valid: grant rr_ptr.
  - Neither valid: no grant.
- reqN_ready = free && (grant == N) && reqN_valid.
  - At most one ready is high per cycle.
  - A ready never rises for a requester whose valid is low.
- Accept (reqN_valid && reqN_ready at edge N):
  - res_data <= (reqN_a << reqN_shift) truncated to WIDTH bits, taken from the shared submodule.
  - res_id <= N, res_valid <= 1.
  - rr_ptr <= ~N.
  - Latency: result visible 1 cycle after accept.
- Result consumption:
  - res_valid && res_ready with no accept in the same cycle: res_valid <= 0. res_data and res_id keep their last values.
  - Consume and accept in the same cycle: the new result replaces the old one, and res_valid stays 1. This gives full throughput of one operation per cycle while res_ready is held high.
- Stall: res_valid && !res_ready means both ready outputs are low. res_data and res_id are held stable until consumed.
- rr_ptr changes only on an accept, so an idle cycle keeps the fairness state.
- Shift amounts:
  - Shift of 0 passes the operand through unchanged.
  - Shift of 15 keeps only bit 0, moved into bit 15.
  - Bits shifted out are discarded; no carry/overflow output.
- busy_cnt increments by 1 in each cycle where (req0_valid && !req0_ready) || (req1_valid && !req1_ready). It holds at 16'hFFFF.
- Requesters must hold valid and operands stable until accepted. The block samples operands only at the accept edge.
- Reset asserted mid-operation: any pending result is discarded immediately (res_valid drops asynchronously) and the pointer returns to 0. The first accept after reset release uses the arbitration rules above with rr_ptr=0.

Test Plan:
- Reset, then req0 only: A=15, shift=2, res_ready=1 -> req0_ready high 1 cycle. Next cycle res_valid=1, res_data=60, res_id=0. Then res_valid=0.
- Both valid continuously (req0 A=1 shift=15; req1 A=10 shift=0), res_ready=1 -> grants alternate 0,1,0,1 starting with 0. Results alternate 32768/id0 and 10/id1, one per cycle. busy_cnt increments every cycle.
- Backpressure: accept req1 A=3 shift=4, then hold res_ready=0 for 5 cycles with req0 valid -> res_data=48, res_id=1 stable. Both readies low, busy_cnt +5. Release res_ready -> req0 accepted in the same cycle as consumption.
- Pointer retention: accept req0, idle 3 cycles, then both valid -> req1 granted first.
- Assert rst_n low while res_valid=1 (res_data=60) -> res_valid drops without a clock edge; busy_cnt=0. After release, both valid -> req0 granted.
- busy_cnt saturation: hold req1_valid with res_ready=0 and a full result register for 70000 cycles -> busy_cnt=16'hFFFF and stays there.
